// File: rtl/slow_clk_gen.sv
// slow_clk_gen
//   Divides CLK_50 into a 50% duty square wave whose half-period is
//   BASE_HALF >> level. A requested level (freq_num, clamped to the valid
//   range) is only adopted at the end of a full period (terminal count while
//   slow_clk is high), so the output never glitches or truncates a period.
//
// Ports:
//   CLK_50         in   system clock
//   reset          in   synchronous, active-high reset
//   enable         in   run/hold; low freezes cnt, slow_clk and active_num
//   freq_num       in   requested level index (values >= NUM_LEVELS clamp)
//   slow_clk       out  divided square wave
//   tick           out  one-cycle pulse in the cycle slow_clk becomes 1
//   active_num     out  level currently driving the divider
//   change_pending out  request differs from active_num, awaiting boundary
module slow_clk_gen #(
    parameter int unsigned BASE_HALF  = 25000000,
    parameter int unsigned NUM_LEVELS = 6,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned CNT_W      = 25
) (
    input  logic             CLK_50,
    input  logic             reset,
    input  logic             enable,
    input  logic [SEL_W-1:0] freq_num,
    output logic             slow_clk,
    output logic             tick,
    output logic [SEL_W-1:0] active_num,
    output logic             change_pending
);

    localparam logic [SEL_W-1:0] MAX_LEVEL = SEL_W'(NUM_LEVELS - 1);

    logic [SEL_W-1:0] req;
    logic [SEL_W-1:0] req_clamped;
    logic [SEL_W-1:0] active_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_m1;
    logic             terminal;
    logic             apply;

    // Constant table of (half-period - 1) per level, selected by active_num.
    always_comb begin
        half_m1 = '0;
        for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
            if (active_num == SEL_W'(i)) begin
                half_m1 = CNT_W'((BASE_HALF >> i) - 1);
            end
        end
    end

    always_comb begin
        req_clamped = (freq_num > MAX_LEVEL) ? MAX_LEVEL : freq_num;
        terminal    = (cnt == half_m1);
        // Falling-edge boundary with a registered pending request.
        apply       = enable && terminal && slow_clk && change_pending;
        active_next = apply ? req : active_num;
    end

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            cnt            <= '0;
            slow_clk       <= 1'b0;
            tick           <= 1'b0;
            active_num     <= '0;
            req            <= '0;
            change_pending <= 1'b0;
        end else begin
            req <= req_clamped;
            // Compared against the post-apply level so a request adopted at
            // this edge clears pending, while one arriving now stays pending.
            change_pending <= (req_clamped != active_next);
            active_num     <= active_next;
            tick           <= 1'b0;
            if (enable) begin
                if (terminal) begin
                    cnt      <= '0;
                    slow_clk <= ~slow_clk;
                    tick     <= ~slow_clk;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
